// File: rtl/dmem_pkg.sv
// Purpose: shared encodings for the data-memory responder (access sizes, FSM states).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dmem_pkg;

    // Access-size encodings, identical to the CPU decoder's MemSize field.
    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    // Responder FSM states; explicit values keep the encoding stable.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RESPOND = 2'd2
    } state_e;

    function automatic logic size_is_illegal(input logic [1:0] size);
        return size == SIZE_ILLEGAL;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Purpose: load/store request + single-cycle response bundle between CPU (master) and memory (slave).
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready handshake on requests; responses are never stalled.
// Ports: req_* carry one request, rsp_* carry the one-cycle response strobe and its payload.
interface dmem_responder_if #(
    parameter int ADDRESS_BITS = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDRESS_BITS-1:0] req_addr;
    logic [1:0]              req_size;
    logic                    req_sign;
    logic [31:0]             req_wdata;
    logic                    rsp_valid;
    logic [31:0]             rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_sign, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_sign, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Purpose: little-endian lane steering: merges store data into a word and extracts/extends load data.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_size/i_addr_lo/i_sign/i_wdata/i_old_word in; o_store_word, o_load_word, o_misalign out.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_sign,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_old_word,
    output logic [31:0] o_store_word,
    output logic [31:0] o_load_word,
    output logic        o_misalign
);
    logic [4:0]  w_byte_sh;
    logic [4:0]  w_half_sh;
    logic [31:0] w_byte_word;
    logic [31:0] w_half_word;
    logic [31:0] w_mask;
    logic [31:0] w_data;

    // Bit offset of the addressed byte lane and of the addressed half-word.
    assign w_byte_sh   = {i_addr_lo, 3'b000};
    assign w_half_sh   = {i_addr_lo[1], 4'b0000};
    assign w_byte_word = i_old_word >> w_byte_sh;
    assign w_half_word = i_old_word >> w_half_sh;

    always_comb begin
        w_mask      = 32'hFFFF_FFFF;
        w_data      = i_wdata;
        o_load_word = i_old_word;
        o_misalign  = 1'b0;
        case (i_size)
            SIZE_BYTE: begin
                w_mask      = 32'h0000_00FF << w_byte_sh;
                w_data      = {24'h0, i_wdata[7:0]} << w_byte_sh;
                o_load_word = {{24{i_sign & w_byte_word[7]}}, w_byte_word[7:0]};
            end
            SIZE_HALF: begin
                w_mask      = 32'h0000_FFFF << w_half_sh;
                w_data      = {16'h0, i_wdata[15:0]} << w_half_sh;
                o_load_word = {{16{i_sign & w_half_word[15]}}, w_half_word[15:0]};
                o_misalign  = i_addr_lo[0];
            end
            SIZE_WORD: begin
                o_misalign  = |i_addr_lo;
            end
            default: ;
        endcase
    end

    // Unselected lanes keep their old contents.
    assign o_store_word = (i_old_word & ~w_mask) | (w_data & w_mask);
endmodule

// File: rtl/dmem_responder.sv
// Purpose: latency-configurable data-memory slave: byte/half/word loads and stores with range/alignment checks.
// Latency: response strobe LATENCY cycles after accept; next request accepted LATENCY+2 cycles after the last.
// Backpressure: req_ready low from accept until the response cycle ends; responses cannot be stalled.
// Ports: clk, rst (async, active-high), bus (dmem_responder_if slave modport).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDRESS_BITS = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int LATENCY      = 2      // legal 1..15
)(
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    localparam int IDX_BITS = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_we;
    logic [ADDRESS_BITS-1:0] r_addr;
    logic [1:0]              r_size;
    logic                    r_sign;
    logic [31:0]             r_wdata;
    logic [31:0]             r_rsp_rdata;
    logic                    r_rsp_err;
    logic [31:0]             r_mem [DEPTH_WORDS];

    logic                    w_commit;
    logic [ADDRESS_BITS-3:0] w_word_idx;
    logic                    w_oor;
    logic [IDX_BITS-1:0]     w_idx;
    logic [31:0]             w_old_word;
    logic [31:0]             w_store_word;
    logic [31:0]             w_load_word;
    logic                    w_misalign;
    logic                    w_err;

    // The last ACCESS cycle is the single commit point for both reads and writes.
    assign w_commit   = (r_state == S_ACCESS) && (r_cnt == 4'd0);
    assign w_word_idx = r_addr[ADDRESS_BITS-1:2];
    assign w_oor      = {2'b00, w_word_idx} >= ADDRESS_BITS'(DEPTH_WORDS);
    assign w_idx      = r_addr[IDX_BITS+1:2];
    assign w_old_word = r_mem[w_idx];
    assign w_err      = w_misalign | size_is_illegal(r_size) | w_oor;

    dmem_lane_align u_lane_align (
        .i_size       (r_size),
        .i_addr_lo    (r_addr[1:0]),
        .i_sign       (r_sign),
        .i_wdata      (r_wdata),
        .i_old_word   (w_old_word),
        .o_store_word (w_store_word),
        .o_load_word  (w_load_word),
        .o_misalign   (w_misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_size      <= SIZE_BYTE;
            r_sign      <= 1'b0;
            r_wdata     <= 32'h0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_addr  <= bus.req_addr;
                        r_size  <= bus.req_size;
                        r_sign  <= bus.req_sign;
                        r_wdata <= bus.req_wdata;
                        r_cnt   <= 4'(LATENCY - 1);
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (w_commit) begin
                        r_state     <= S_RESPOND;
                        r_rsp_err   <= w_err;
                        // Stores and rejected requests return zero data.
                        r_rsp_rdata <= (w_err || r_we) ? 32'h0 : w_load_word;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESPOND: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Array is not reset; an asserted rst holds r_state in IDLE so no write can slip through.
    always_ff @(posedge clk) begin
        if (w_commit && r_we && !w_err) begin
            r_mem[w_idx] <= w_store_word;
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESPOND);
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int AB    = 32;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDRESS_BITS(AB)) bus ();

    dmem_responder #(.ADDRESS_BITS(AB), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;          // number of rising edges seen so far
    always @(posedge clk) ncyc++;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] wdata;
        int          acc;    // accept edge
        int          rsp;    // edge after which the response is visible
    } req_t;

    req_t        pend[$];
    logic [31:0] mm [int];   // reference memory, word granular
    int          rsp_edges[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: what a little-endian byte memory must return / hold.
    function automatic void model_eval(input req_t r, output logic [31:0] rd, output logic err);
        logic [31:0] idx;
        logic [31:0] w;
        logic [31:0] part;
        int          sh;
        idx = r.addr >> 2;
        err = (r.size == 2'b11) ||
              (r.size == SIZE_HALF && r.addr[0]) ||
              (r.size == SIZE_WORD && r.addr[1:0] != 2'b00) ||
              (idx >= DEPTH);
        rd = 32'h0;
        if (err) return;
        w = mm.exists(int'(idx)) ? mm[int'(idx)] : 32'h0;
        if (r.size == SIZE_BYTE) begin
            sh   = int'(r.addr[1:0]) * 8;
            part = (w >> sh) & 32'hFF;
            if (r.we) mm[int'(idx)] = (w & ~(32'hFF << sh)) | ((r.wdata & 32'hFF) << sh);
            else      rd = (r.sign && part[7]) ? (part | 32'hFFFF_FF00) : part;
        end else if (r.size == SIZE_HALF) begin
            sh   = int'(r.addr[1]) * 16;
            part = (w >> sh) & 32'hFFFF;
            if (r.we) mm[int'(idx)] = (w & ~(32'hFFFF << sh)) | ((r.wdata & 32'hFFFF) << sh);
            else      rd = (r.sign && part[15]) ? (part | 32'hFFFF_0000) : part;
        end else begin
            if (r.we) mm[int'(idx)] = r.wdata;
            else      rd = w;
        end
    endfunction

    // Cycle-by-cycle compare against the reference timing and data.
    always @(negedge clk) begin
        logic        exp_rdy;
        logic        exp_vld;
        logic [31:0] rd;
        logic        er;
        req_t        nr;
        if (rst) begin
            pend.delete();
            exp_rdy = 1'b1;
            exp_vld = 1'b0;
        end else begin
            exp_vld = (pend.size() > 0) && (pend[0].rsp == ncyc);
            exp_rdy = !((pend.size() > 0) && ncyc >= pend[0].acc && ncyc <= pend[0].rsp);
        end
        chk("req_ready", {31'h0, bus.req_ready}, {31'h0, exp_rdy});
        chk("rsp_valid", {31'h0, bus.rsp_valid}, {31'h0, exp_vld});
        if (bus.rsp_valid && !rst) rsp_edges.push_back(ncyc);
        if (exp_vld) begin
            model_eval(pend[0], rd, er);
            chk("rsp_rdata", bus.rsp_rdata, rd);
            chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, er});
            void'(pend.pop_front());
        end
        if (!rst && bus.req_valid && bus.req_ready) begin
            nr.we = bus.req_we; nr.addr = bus.req_addr; nr.size = bus.req_size;
            nr.sign = bus.req_sign; nr.wdata = bus.req_wdata;
            nr.acc = ncyc + 1; nr.rsp = ncyc + 1 + LAT;
            pend.push_back(nr);
        end
    end

    // Present a request and wait for it to be accepted; req_valid is left high.
    task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic sign, input logic [31:0] wdata);
        bit ok;
        ok = 1'b0;
        bus.req_we = we; bus.req_addr = addr; bus.req_size = size;
        bus.req_sign = sign; bus.req_wdata = wdata; bus.req_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no req_ready expected accept of addr %h", addr);
        end
    endtask

    // Full transaction with literal expected response; returns response delay in negedges.
    task automatic xact(input string name, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic sign, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, output int lat);
        send(we, addr, size, sign, wdata);
        bus.req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin lat = k; break; end
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no rsp_valid expected response", name);
        end else begin
            chk({name, "_rdata"}, bus.rsp_rdata, exp_rd);
            chk({name, "_err"}, {31'h0, bus.rsp_err}, {31'h0, exp_err});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_size = SIZE_WORD; bus.req_sign = 1'b0; bus.req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_err",   {31'h0, bus.rsp_err}, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Latency and ready profile on a word store.
        send(1'b1, 32'h10, SIZE_WORD, 1'b0, 32'hDEADBEEF);
        bus.req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin lat = k; break; end
            chk("busy_ready", {31'h0, bus.req_ready}, 32'h0);
        end
        chk("store_latency", lat, LAT + 1);
        chk("store_rdata", bus.rsp_rdata, 32'h0);
        chk("store_err", {31'h0, bus.rsp_err}, 32'h0);
        chk("rsp_cycle_ready", {31'h0, bus.req_ready}, 32'h0);
        @(negedge clk);
        chk("ready_back", {31'h0, bus.req_ready}, 32'h1);
        chk("valid_one_cycle", {31'h0, bus.rsp_valid}, 32'h0);
        @(posedge clk); #1;

        xact("lb_s_13", 1'b0, 32'h13, SIZE_BYTE, 1'b1, 32'h0, 32'hFFFF_FFDE, 1'b0, lat);
        xact("lh_u_12", 1'b0, 32'h12, SIZE_HALF, 1'b0, 32'h0, 32'h0000_DEAD, 1'b0, lat);
        xact("lh_s_10", 1'b0, 32'h10, SIZE_HALF, 1'b1, 32'h0, 32'hFFFF_BEEF, 1'b0, lat);
        xact("sb_11",   1'b1, 32'h11, SIZE_BYTE, 1'b0, 32'hFFFF_FF7F, 32'h0, 1'b0, lat);
        xact("lw_10",   1'b0, 32'h10, SIZE_WORD, 1'b0, 32'h0, 32'hDEAD_7FEF, 1'b0, lat);

        // Rejected requests.
        xact("lw_mis",  1'b0, 32'h12, SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b1, lat);
        xact("sh_mis",  1'b1, 32'h11, SIZE_HALF, 1'b0, 32'h1111_2222, 32'h0, 1'b1, lat);
        xact("sz_ill",  1'b0, 32'h10, 2'b11,     1'b0, 32'h0, 32'h0, 1'b1, lat);
        xact("lw_oor",  1'b0, 32'(DEPTH * 4), SIZE_WORD, 1'b0, 32'h0, 32'h0, 1'b1, lat);
        xact("lw_after_err", 1'b0, 32'h10, SIZE_WORD, 1'b0, 32'h0, 32'hDEAD_7FEF, 1'b0, lat);

        // Back-to-back loads with req_valid held high.
        rsp_edges.delete();
        send(1'b0, 32'h10, SIZE_WORD, 1'b0, 32'h0);
        send(1'b0, 32'h13, SIZE_BYTE, 1'b0, 32'h0);
        send(1'b0, 32'h12, SIZE_HALF, 1'b1, 32'h0);
        bus.req_valid = 1'b0;
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk("b2b_count", rsp_edges.size(), 32'd3);
        if (rsp_edges.size() == 3) begin
            chk("b2b_gap1", rsp_edges[1] - rsp_edges[0], LAT + 2);
            chk("b2b_gap2", rsp_edges[2] - rsp_edges[1], LAT + 2);
        end

        // Reset during ACCESS drops the pending store.
        xact("sw_20", 1'b1, 32'h20, SIZE_WORD, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0, lat);
        send(1'b1, 32'h20, SIZE_WORD, 1'b0, 32'h1234_5678);
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("mid_rst_ready", {31'h0, bus.req_ready}, 32'h1);
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        xact("lw_20_after_rst", 1'b0, 32'h20, SIZE_WORD, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, lat);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder: the slave end of the CPU's load/store interface, replacing the zero-latency data array with a handshaked, latency-configurable memory. It accepts one request at a time, performs byte/half/word loads and stores on a little-endian word array with alignment and range checking, and returns a single-cycle response. It is the target for the multi-cycle and pipelined CPU variants' memory stage.

Parameters:
ADDRESS_BITS, 32, width of req_addr.
DEPTH_WORDS, 1024, number of 32-bit words in the backing array.
LATENCY, 2, cycles spent in ACCESS (legal range 1..15).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  responder can accept a request.
req_we  in  1  1 = store, 0 = load.
req_addr  in  ADDRESS_BITS  byte address.
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
req_sign  in  1  load sign-extend enable; ignored for stores.
req_wdata  in  32  store data, right-aligned.
rsp_valid  out  1  one-cycle response strobe.
rsp_rdata  out  32  load result; 0 for stores and for errors.
rsp_err  out  1  request rejected (misaligned, illegal size, or out of range).

Behaviour:
- Reset (asynchronous, active-high) forces: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. The memory array is not reset.
- FSM states: IDLE, ACCESS, RESPOND.
  - IDLE: req_ready=1. If req_valid=1 at a rising edge, latch we/addr/size/sign/wdata, load the counter with LATENCY-1, and go to ACCESS.
  - ACCESS: req_ready=0. Decrement the counter each cycle. When the counter is 0, go to RESPOND at the next edge.
  - RESPOND: rsp_valid=1 for exactly one cycle and req_ready=0. Then go to IDLE unconditionally. There is no response backpressure.
- Timing: if the request is accepted at edge E0:
  - rsp_valid, rsp_rdata and rsp_err become valid after edge E0+LATENCY.
  - req_ready returns to 1 after edge E0+LATENCY+1.
  - Back-to-back throughput is one request per LATENCY+2 cycles.
- Commit point: the store write and the load read both occur at edge E0+LATENCY, the ACCESS→RESPOND edge. Request inputs are don't-care after the accept edge.
- Error checks, evaluated on latched fields:
  - size=11 is an error.
  - Half with addr[0]=1 is an error.
  - Word with addr[1:0]≠00 is an error.
  - Word index addr[ADDRESS_BITS-1:2] ≥ DEPTH_WORDS is an error.
  - On error: no array write, rsp_rdata=0, rsp_err=1.
- Stores, little-endian:
  - Byte: writes wdata[7:0] into the lane selected by addr[1:0].
  - Half: writes wdata[15:0] into lanes {addr[1],0}+1:{addr[1],0}.
  - Word: writes the full word.
  - Unselected lanes are preserved (read-modify-write within the cycle or per-lane enables).
- Loads: extract the byte or half at the lane offset. If req_sign=1, sign-extend from bit 7 or 15; otherwise zero-extend. A word load ignores req_sign.
- Store responses: rsp_rdata=0 and rsp_err=0 on success.
- rsp_rdata/rsp_err hold their value outside RESPOND. rsp_valid alone qualifies them.
- Reset mid-operation: a reset asserted before the commit edge drops the pending store (no array write). A reset during RESPOND clears rsp_valid immediately (asynchronous).
- A req_valid deasserted without being accepted is legal and has no effect.

Decomposition:
- Shared package dmem_pkg:
  - Size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10.
  - FSM state enum {IDLE, ACCESS, RESPOND}.
  - Store to the same size constants the CPU decoder uses for MemSize.
- One combinational sub-module, dmem_lane_align:
  - Inputs: size, addr[1:0], sign, wdata, old word.
  - Outputs: merged store word, extracted and extended load word, misalignment flag.
  - The top-level module holds the FSM, counter, array and range check.

Test Plan:
- Latency (LATENCY=2): store word 0xDEADBEEF @0x10 accepted at E0 → rsp_valid high only in the cycle after E2, rsp_err=0, rsp_rdata=0; req_ready=0 from E0 to E3, then 1.
- After the above, signed byte load @0x13 → 0xFFFFFFDE. Unsigned half load @0x12 → 0x0000DEAD. Signed half load @0x10 → 0xFFFFBEEF.
- Store byte 0x7F @0x11, then word load @0x10 → 0xDEAD7FEF (other lanes preserved).
- Word load @0x12, half store @0x11, size=11, and word @ (DEPTH_WORDS*4) → each gives rsp_err=1, rsp_rdata=0. A subsequent word load @0x10 still returns 0xDEAD7FEF.
- req_valid held high continuously with 3 queued loads → exactly 3 rsp_valid pulses spaced LATENCY+2 cycles apart, each returning the correct data.
- Store 0x12345678 @0x20; assert rst during ACCESS → rsp_valid=0 and req_ready=1 immediately. A later load @0x20 returns the prior contents, not 0x12345678.
